// File: rtl/alv_mul_pkg.sv
// Shared defaults and helpers for the round-robin multiplier arbiter.
package alv_mul_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_REQ_DEF  = 4;

    // Requester index width; one bit minimum so a single-entry port stays legal.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alv_mul_pipe.sv
// Signed DATA_W x DATA_W multiplier with one ce-gated register stage.
module alv_mul_pipe
    import alv_mul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic        [DATA_W-1:0] y
);

    // Only the low half of the product is kept, which wraps identically for signed operands.
    logic signed [DATA_W-1:0] prod_lo;

    assign prod_lo = a * b;

    always_ff @(posedge clk) begin
        if (reset) begin
            y <= '0;
        end else if (ce) begin
            y <= prod_lo;
        end
    end

endmodule

// File: rtl/alv_vhdl_mul_arbiter.sv
// Round-robin arbiter feeding a shared one-stage multiplier with a tagged,
// back-pressured result port.
module alv_vhdl_mul_arbiter
    import alv_mul_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    output logic [ID_W-1:0]         resp_id,
    input  logic                    resp_ready
);

    logic [ID_W-1:0]   rr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   rr_next;
    logic [N_REQ-1:0]  grant;
    logic              found;
    logic              stall;
    logic              ce;
    logic              xfer;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;

    assign stall = resp_valid & ~resp_ready;
    assign ce    = ~stall;

    // First valid requester at or after rr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = ID_W'(idx);
            end
        end
    end

    assign req_ready = (reset || stall) ? '0 : grant;
    assign xfer      = |(req_ready & req_valid);

    always_comb begin
        int w1;
        w1 = int'(winner) + 1;
        if (w1 >= N_REQ) begin
            w1 = 0;
        end
        rr_next = ID_W'(w1);
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*DATA_W +: DATA_W];
                b_sel = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr         <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
        end else if (ce) begin
            resp_valid <= xfer;
            resp_id    <= winner;
            if (xfer) begin
                rr <= rr_next;
            end
        end
    end

    alv_mul_pipe #(
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .a     (a_sel),
        .b     (b_sel),
        .y     (resp_data)
    );

endmodule

// File: tb/tb_alv_vhdl_mul_arbiter.sv
// Directed and random stimulus for alv_vhdl_mul_arbiter against a queue-based
// reference of grants and outstanding results.
module tb_alv_vhdl_mul_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [1:0]    resp_id;
    logic          resp_ready;

    alv_vhdl_mul_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
    } result_t;

    result_t     pending[$];
    int          m_rr;
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] op_a[N];
    logic [31:0] op_b[N];
    int          grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wrap_mul(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        longint p;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        return p[31:0];
    endfunction

    // One clock: apply inputs, check comb and registered outputs, advance the model.
    task automatic cyc(input logic rst, input logic [N-1:0] v, input logic rdy);
        logic [N-1:0] g;
        int           w;
        logic         stall;
        logic         hs;
        result_t      r;
        reset      = rst;
        req_valid  = v;
        resp_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = op_a[i];
            req_b[i*DW +: DW] = op_b[i];
        end
        #2;
        stall = (pending.size() != 0) && !rdy;
        g = '0;
        w = -1;
        if (!rst && !stall) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && v[(m_rr + k) % N]) begin
                    w = (m_rr + k) % N;
                end
            end
            if (w >= 0) g[w] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(g));
        chk("resp_valid", 64'(resp_valid), 64'(pending.size() != 0));
        if (pending.size() != 0) begin
            chk("resp_data", 64'(resp_data), 64'(pending[0].data));
            chk("resp_id", 64'(resp_id), 64'(pending[0].id));
        end
        hs = (pending.size() != 0) && rdy;
        @(posedge clk);
        if (rst) begin
            pending.delete();
            m_rr = 0;
        end else begin
            if (hs) void'(pending.pop_front());
            if (w >= 0) begin
                r.data = wrap_mul(op_a[w], op_b[w]);
                r.id   = 2'(w);
                pending.push_back(r);
                grant_log.push_back(w);
                m_rr = (w + 1) % N;
            end
        end
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        m_rr       = 0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 32'(i + 1);
            op_b[i] = 32'(i + 5);
        end
        @(posedge clk);
        #1;

        // Reset, including valid requesters that must not be granted.
        cyc(1'b1, 4'b1111, 1'b1);
        cyc(1'b1, 4'b0000, 1'b1);
        #2;
        chk("rst_data", 64'(resp_data), 64'h0);
        chk("rst_id", 64'(resp_id), 64'h0);

        // Single transfer: 7 * -3.
        op_a[0] = 32'd7;
        op_b[0] = 32'hFFFF_FFFD;
        cyc(1'b0, 4'b0001, 1'b1);
        #2;
        chk("neg_product", 64'(resp_data), 64'hFFFF_FFEB);
        chk("neg_product_id", 64'(resp_id), 64'h0);
        cyc(1'b0, 4'b0000, 1'b1);

        // All requesters valid: rotation 0,1,2,3,0 (rr already advanced to 1 above, so reset first).
        cyc(1'b1, 4'b0000, 1'b1);
        grant_log.delete();
        for (int k = 0; k < 5; k++) cyc(1'b0, 4'b1111, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);
        chk("rotation_len", 64'(grant_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            chk("rotation", 64'(grant_log[k]), 64'(k % N));
        end

        // Wraparound corner operands.
        op_a[1] = 32'h8000_0000;
        op_b[1] = 32'hFFFF_FFFF;
        cyc(1'b0, 4'b0010, 1'b1);
        #2;
        chk("min_times_neg1", 64'(resp_data), 64'h8000_0000);
        op_a[1] = 32'h0001_0000;
        op_b[1] = 32'h0001_0000;
        cyc(1'b0, 4'b0010, 1'b1);
        #2;
        chk("overflow_wrap", 64'(resp_data), 64'h0);
        cyc(1'b0, 4'b0000, 1'b1);

        // Stall for three cycles with requesters 1 and 2 waiting.
        cyc(1'b0, 4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 4'b0110, 1'b0);
        cyc(1'b0, 4'b0110, 1'b1);
        cyc(1'b0, 4'b0110, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);

        // Reset while a result is stalled: it must be discarded, grants restart at 0.
        cyc(1'b0, 4'b0100, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0101, 1'b0);
        grant_log.delete();
        cyc(1'b0, 4'b0101, 1'b1);
        chk("post_reset_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));
        cyc(1'b0, 4'b0100, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);

        // Single requester streaming back to back.
        grant_log.delete();
        for (int k = 0; k < 8; k++) begin
            op_a[2] = $urandom();
            op_b[2] = $urandom();
            cyc(1'b0, 4'b0100, 1'b1);
        end
        cyc(1'b0, 4'b0000, 1'b1);
        chk("stream_count", 64'(grant_log.size()), 64'd8);

        // Random traffic with random back-pressure and occasional reset.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                op_a[i] = $urandom();
                op_b[i] = $urandom();
            end
            cyc(($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 3; k++) cyc(1'b0, 4'b0000, 1'b1);
        chk("drained", 64'(pending.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
